stopwatch_core: RTL
===================

Name: stopwatch_core

Overview:
Stopwatch timebase and state machine that sits directly upstream of the display controller. It produces the four BCD digits that the display controller shows while enable_stopwatch is high. The digits read SS.cc, from 00.00 to 99.99, in hundredths of a second. The block handles start/stop, lap freeze, clear and overflow saturation from two single-cycle button pulses that are debounced upstream.

Parameters:
TICK_DIV, 1_000_000, clk cycles per 10 ms tick (100 MHz clock); benches override this to a small value.

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-low reset
enable_stopwatch  input  1  stopwatch mode selected; button pulses are ignored when low
btn_start_stop  input  1  single-cycle pulse: start, stop or resume
btn_lap_reset  input  1  single-cycle pulse: lap freeze/release, or clear when paused
stop_time_0  output  4  hundredths, ones digit (BCD)
stop_time_1  output  4  hundredths, tens digit (BCD)
stop_time_2  output  4  seconds, ones digit (BCD)
stop_time_3  output  4  seconds, tens digit (BCD)
running  output  1  high in RUN or LAP
lap_active  output  1  high in LAP
overflow  output  1  sticky; set when the count saturates at 99.99

Behaviour:
- All registers update on posedge clk. When reset==0 at an edge: state=IDLE, count=0000, snapshot=0000, prescaler=0, all outputs 0.
- Prescaler:
  - Increments only in RUN or LAP. At TICK_DIV-1 it asserts tick for that cycle and wraps to 0.
  - Holds its value in PAUSED, so resume continues the partial interval.
  - Cleared on entry to IDLE.
- Count is a 4-digit BCD cascade, each digit 0-9:
  - On tick, digit0 increments. A carry ripples within the same cycle: 0009 -> 0010, 0099 -> 0100, 0999 -> 1000.
  - A non-BCD value never appears on any output.
- Overflow:
  - A tick while count==9999 does not increment. Count stays 9999, overflow<=1, and state<=PAUSED on that edge.
  - From LAP, the display returns to live 99.99.
- Outputs:
  - In IDLE, RUN and PAUSED, stop_time_* equal the count registers. The new value is visible the cycle after the tick edge.
  - In LAP, stop_time_* equal the snapshot register.
- Button qualification: a pulse acts only if enable_stopwatch==1 in the same cycle. enable_stopwatch has no effect on counting.
- If both pulses are high in the same cycle, btn_start_stop wins and btn_lap_reset is ignored.
- FSM transitions, taken on the edge where the pulse is sampled:
  - IDLE: start_stop -> RUN. lap_reset ignored.
  - RUN: start_stop -> PAUSED. lap_reset -> LAP; snapshot<=count as it stood before any same-edge tick increment.
  - LAP: count keeps running. start_stop -> PAUSED (display shows live count). lap_reset -> RUN (display released).
  - PAUSED: start_stop -> RUN, unless overflow==1, in which case it is ignored. lap_reset -> IDLE: count=0000, prescaler=0, overflow=0.
- Reset asserted mid-run overrides everything on that edge. No tick is counted and no pulse is acted on.
- States are encoded in 2 bits. running and lap_active are registered decodes of the next state, valid the same cycle as the state register.

Decomposition:
- Shared package holds:
  - the state encoding constants IDLE=0, RUN=1, PAUSED=2, LAP=3;
  - the TICK_DIV default;
  - the BCD max-digit constant 9.
- One sub-module is natural: bcd_digit_counter.
  - Ports: clk, reset, inc, clr; outputs digit[3:0] and carry_out (carry_out = inc && digit==9).
  - Instantiated four times, chained inc <- previous carry_out.
  - Saturation at 9999 is enforced by the parent gating the first inc.

Test Plan:
1. TICK_DIV=4, release reset, pulse start at cycle 0 -> running=1 next cycle; stop_time = 0,0,0,1 (s3..s0) after 4 cycles; 0010 after 40 cycles.
2. Run to 0099 and let one more tick occur -> 0100 with no intermediate non-BCD value; pulse start -> PAUSED, count frozen for 20 cycles; pulse start again -> resumes with no lost partial tick.
3. At 0123 pulse lap -> outputs hold 0123 and lap_active=1 while the internal count advances; after 3 ticks pulse lap -> outputs show 0126, lap_active=0.
4. Pulse start and lap in the same cycle from RUN -> PAUSED, no snapshot taken; then pulse lap -> IDLE, outputs 0000, overflow=0.
5. Preload to 9998 by running -> two ticks later outputs 9999, overflow=1, running=0; start pulse ignored; lap pulse clears to 0000 and overflow=0.
6. enable_stopwatch=0 with start pulses -> no state change. Drive reset=0 for one cycle mid-run at 0456 -> all outputs 0000 and IDLE on the next cycle.

Source files
------------

// File: rtl/stopwatch_core_pkg.sv
// Shared definitions for the stopwatch core: FSM state encoding, timebase
// default and the BCD digit limit.
package stopwatch_core_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRun    = 2'd1,
      StPaused = 2'd2,
      StLap    = 2'd3
   } sw_state_e;

   // clk cycles per 10 ms tick at 100 MHz
   localparam int unsigned TickDivDefault = 1_000_000;

   localparam logic [3:0] BcdMax = 4'd9;

endpackage

// File: rtl/stopwatch_core_bcd_digit_counter.sv
// Single BCD digit (0-9) with increment, clear and combinational carry.
// Ports:
//   clk       - system clock
//   reset     - synchronous active-low reset
//   inc       - advance the digit this cycle
//   clr       - force the digit to 0 (wins over inc)
//   digit     - current digit value
//   carry_out - inc while at 9; feeds the next digit's inc in the same cycle
module bcd_digit_counter
   import stopwatch_core_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       inc,
   input  logic       clr,
   output logic [3:0] digit,
   output logic       carry_out
);

   logic [3:0] digit_q, digit_d;

   always_comb begin
      digit_d = digit_q;
      if (clr) begin
         digit_d = 4'd0;
      end else if (inc) begin
         digit_d = (digit_q == BcdMax) ? 4'd0 : digit_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         digit_q <= 4'd0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit     = digit_q;
   assign carry_out = inc && (digit_q == BcdMax);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timebase and control FSM. Counts SS.cc in BCD from 00.00 to
// 99.99, with start/stop, lap freeze, clear and sticky overflow saturation.
// Ports:
//   clk, reset             - clock, synchronous active-low reset
//   enable_stopwatch       - qualifies the button pulses (not counting)
//   btn_start_stop         - start / stop / resume pulse
//   btn_lap_reset          - lap freeze/release, or clear when paused
//   stop_time_0..3         - displayed digits, hundredths ones .. seconds tens
//   running, lap_active    - registered decodes of the FSM state
//   overflow               - sticky saturation flag
module stopwatch_core
   import stopwatch_core_pkg::*;
#(
   parameter int unsigned TICK_DIV = TickDivDefault
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable_stopwatch,
   input  logic       btn_start_stop,
   input  logic       btn_lap_reset,
   output logic [3:0] stop_time_0,
   output logic [3:0] stop_time_1,
   output logic [3:0] stop_time_2,
   output logic [3:0] stop_time_3,
   output logic       running,
   output logic       lap_active,
   output logic       overflow
);

   localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);

   sw_state_e       state_q, state_d;
   logic [PreW-1:0] presc_q, presc_d;
   logic [15:0]     snap_q, snap_d;
   logic            ovf_q, ovf_d;
   logic            running_q, lap_q;

   logic [3:0]  digit [4];
   logic [3:0]  carry;
   logic [3:0]  inc;
   logic [15:0] count;
   logic        active, tick, at_max, ss, lr, clr;
   logic        unused_top_carry;

   assign active = (state_q == StRun) || (state_q == StLap);
   assign tick   = active && (presc_q == PreMax);
   assign count  = {digit[3], digit[2], digit[1], digit[0]};
   assign at_max = (count == 16'h9999);
   assign ss     = enable_stopwatch && btn_start_stop;
   // start/stop has priority over a simultaneous lap/reset pulse
   assign lr     = enable_stopwatch && btn_lap_reset && !btn_start_stop;

   // Saturation: the first digit is never advanced past 99.99
   assign inc = {carry[2:0], tick && !at_max};
   assign unused_top_carry = carry[3];

   for (genvar g = 0; g < 4; g++) begin : g_digit
      bcd_digit_counter u_digit (
         .clk      (clk),
         .reset    (reset),
         .inc      (inc[g]),
         .clr      (clr),
         .digit    (digit[g]),
         .carry_out(carry[g])
      );
   end

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      snap_d  = snap_q;
      ovf_d   = ovf_q;
      clr     = 1'b0;

      if (active) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (ss) state_d = StRun;
         end
         StRun: begin
            if (ss) begin
               state_d = StPaused;
            end else if (lr) begin
               state_d = StLap;
               snap_d  = count;  // pre-increment value, even on a tick edge
            end
         end
         StLap: begin
            if (ss) begin
               state_d = StPaused;
            end else if (lr) begin
               state_d = StRun;
            end
         end
         StPaused: begin
            if (ss) begin
               if (!ovf_q) state_d = StRun;
            end else if (lr) begin
               state_d = StIdle;
               presc_d = '0;
               ovf_d   = 1'b0;
               clr     = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (tick && at_max) begin
         state_d = StPaused;
         ovf_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= StIdle;
         presc_q   <= '0;
         snap_q    <= '0;
         ovf_q     <= 1'b0;
         running_q <= 1'b0;
         lap_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         snap_q    <= snap_d;
         ovf_q     <= ovf_d;
         running_q <= (state_d == StRun) || (state_d == StLap);
         lap_q     <= (state_d == StLap);
      end
   end

   logic [15:0] disp;
   assign disp = (state_q == StLap) ? snap_q : count;

   assign stop_time_0 = disp[3:0];
   assign stop_time_1 = disp[7:4];
   assign stop_time_2 = disp[11:8];
   assign stop_time_3 = disp[15:12];
   assign running     = running_q;
   assign lap_active  = lap_q;
   assign overflow    = ovf_q;

endmodule
